// File: rtl/sram_pattern_bist.sv
// SRAM pattern self-test controller.
// Writes a mode-selected pattern to every word, then reads each word back and
// compares it, reporting pass/fail, a saturating error count and the first
// failing address. In IDLE/DONE a manual read port presents a switch-set
// address to the SRAM and captures the returned data for display.
module sram_pattern_bist #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 7,
    parameter int DEPTH  = 128,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              manual_en,
    input  logic [ADDR_W-1:0] manual_addr,
    output logic              mem_cs_n,
    output logic              mem_oe_n,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_fail,
    output logic [DATA_W-1:0] manual_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_SETUP,
        S_W_STROBE,
        S_W_HOLD,
        S_R_ISSUE,
        S_R_WAIT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam int                WC_W      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WC_W-1:0]   LAST_WAIT = WC_W'(RD_LAT - 1);

    // Expected data word for a given pattern mode and address.
    function automatic logic [DATA_W-1:0] pattern_word(input logic [1:0]        m,
                                                       input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] av;
        logic [DATA_W-1:0] chk;
        av = DATA_W'(a);
        // "0101.." read MSB first: MSB is 0, bits alternate downwards
        for (int i = 0; i < DATA_W; i++) begin
            chk[i] = (((DATA_W - 1 - i) % 2) == 1);
        end
        case (m)
            2'd0:    pattern_word = {DATA_W{1'b1}} - av;
            2'd1:    pattern_word = av;
            2'd2:    pattern_word = a[0] ? chk : ~chk;
            default: pattern_word = ~av;
        endcase
    endfunction

    // Error counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (&c) ? c : c + CNT_W'(1);
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic [1:0]        mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] first_fail_q, first_fail_d;
    logic [DATA_W-1:0] manual_data_q, manual_data_d;
    logic              mem_cs_n_q, mem_cs_n_d;
    logic              mem_oe_n_q, mem_oe_n_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // Next-state, status and registered bus-control decode.
    always_comb begin
        logic mismatch;
        mismatch      = 1'b0;
        state_d       = state_q;
        addr_d        = addr_q;
        wait_d        = wait_q;
        mode_d        = mode_q;
        busy_d        = busy_q;
        done_d        = done_q;
        pass_d        = pass_q;
        err_d         = err_q;
        first_fail_d  = first_fail_q;
        manual_data_d = manual_data_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_W_SETUP;
                    addr_d       = '0;
                    mode_d       = mode;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_d        = '0;
                    first_fail_d = '0;
                end else if (manual_en) begin
                    manual_data_d = mem_rdata;
                end
            end
            S_W_SETUP:  state_d = S_W_STROBE;
            S_W_STROBE: state_d = S_W_HOLD;
            S_W_HOLD: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_R_ISSUE;
                    addr_d  = '0;
                end else begin
                    state_d = S_W_SETUP;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            S_R_ISSUE: begin
                state_d = S_R_WAIT;
                wait_d  = '0;
            end
            S_R_WAIT: begin
                if (wait_q == LAST_WAIT) begin
                    mismatch = (mem_rdata != pattern_word(mode_q, addr_q));
                    if (mismatch) begin
                        err_d = sat_inc(err_q);
                        if (err_q == '0) first_fail_d = addr_q;
                    end
                    if (addr_q == LAST_ADDR) begin
                        // address stays at the last word; no wrap
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_q == '0) && !mismatch;
                    end else begin
                        state_d = S_R_ISSUE;
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                end else begin
                    wait_d = wait_q + WC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus outputs are registered, so they follow the state being entered.
        mem_cs_n_d  = 1'b1;
        mem_oe_n_d  = 1'b1;
        mem_rw_d    = 1'b1;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_d)
            S_W_SETUP: begin
                mem_rw_d    = 1'b0;
                mem_addr_d  = addr_d;
                mem_wdata_d = pattern_word(mode_d, addr_d);
            end
            S_W_STROBE: begin
                mem_rw_d   = 1'b0;
                mem_cs_n_d = 1'b0;
            end
            S_W_HOLD: mem_rw_d = 1'b0;
            S_R_ISSUE, S_R_WAIT: begin
                mem_cs_n_d = 1'b0;
                mem_oe_n_d = 1'b0;
                mem_addr_d = addr_d;
            end
            S_IDLE, S_DONE: begin
                if (manual_en) begin
                    mem_cs_n_d = 1'b0;
                    mem_oe_n_d = 1'b0;
                    mem_addr_d = manual_addr;
                end
            end
            default: ;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            wait_q        <= '0;
            mode_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_q         <= '0;
            first_fail_q  <= '0;
            manual_data_q <= '0;
            mem_cs_n_q    <= 1'b1;
            mem_oe_n_q    <= 1'b1;
            mem_rw_q      <= 1'b1;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wait_q        <= wait_d;
            mode_q        <= mode_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            err_q         <= err_d;
            first_fail_q  <= first_fail_d;
            manual_data_q <= manual_data_d;
            mem_cs_n_q    <= mem_cs_n_d;
            mem_oe_n_q    <= mem_oe_n_d;
            mem_rw_q      <= mem_rw_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign mem_cs_n    = mem_cs_n_q;
    assign mem_oe_n    = mem_oe_n_q;
    assign mem_rw      = mem_rw_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_count   = err_q;
    assign first_fail  = first_fail_q;
    assign manual_data = manual_data_q;

endmodule

// File: tb/tb_sram_pattern_bist.sv
// Bench for sram_pattern_bist: two instances (128 words / RD_LAT 1 with a
// stuck-at-0 fault-injecting memory, and 100 words / RD_LAT 3 ideal memory).
module tb_sram_pattern_bist;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // ---------------- instance A: DEPTH 128, RD_LAT 1 ----------------
    logic       start_a, men_a;
    logic [1:0] mode_a;
    logic [6:0] maddr_a, addr_a, ff_a;
    logic [6:0] wdata_a, rdata_a, mdata_a;
    logic       cs_n_a, oe_n_a, rw_a, busy_a, done_a, pass_a;
    logic [7:0] err_a;
    logic [6:0] mem_a [128];
    logic [6:0] sa0_a [128];
    int         wr_a  = 0;
    int         rw0_a = 0;

    sram_pattern_bist #(.ADDR_W(7), .DATA_W(7), .DEPTH(128), .RD_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .mode(mode_a),
        .manual_en(men_a), .manual_addr(maddr_a),
        .mem_cs_n(cs_n_a), .mem_oe_n(oe_n_a), .mem_rw(rw_a),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_rdata(rdata_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail(ff_a), .manual_data(mdata_a)
    );

    // ---------------- instance B: DEPTH 100, RD_LAT 3 ----------------
    logic       start_b;
    logic [1:0] mode_b;
    logic [6:0] addr_b, ff_b, wdata_b, rdata_b, mdata_b, p1_b, p2_b;
    logic       cs_n_b, oe_n_b, rw_b, busy_b, done_b, pass_b;
    logic [6:0] err_b;
    logic [6:0] mem_b [128];
    logic [6:0] max_b = '0;

    sram_pattern_bist #(.ADDR_W(7), .DATA_W(7), .DEPTH(100), .RD_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .mode(mode_b),
        .manual_en(1'b0), .manual_addr(7'd0),
        .mem_cs_n(cs_n_b), .mem_oe_n(oe_n_b), .mem_rw(rw_b),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail(ff_b), .manual_data(mdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory A: write on strobe, one-cycle read with stuck-at-0 fault masks.
    always @(posedge clk) begin
        if (!cs_n_a && !rw_a) mem_a[addr_a] <= wdata_a;
        rdata_a <= mem_a[addr_a] & ~sa0_a[addr_a];
    end

    // Memory A bus monitor: write strobes and write-phase cycles.
    always @(posedge clk) begin
        if (!reset && !cs_n_a && !rw_a) wr_a <= wr_a + 1;
        if (!reset && !rw_a) rw0_a <= rw0_a + 1;
    end

    // Memory B: ideal, three-cycle read pipeline; track highest busy address.
    always @(posedge clk) begin
        if (!cs_n_b && !rw_b) mem_b[addr_b] <= wdata_b;
        p1_b    <= mem_b[addr_b];
        p2_b    <= p1_b;
        rdata_b <= p2_b;
        if (busy_b && addr_b > max_b) max_b <= addr_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start a run on A and return cycles from the start edge until done.
    task automatic run_a(input logic [1:0] m, output int lat);
        @(negedge clk);
        mode_a  = m;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        mode_a  = ~m;
        check("start_busy", busy_a, 1);
        check("start_addr", addr_a, 0);
        check("start_rw",   rw_a,   0);
        lat = 0;
        while (!done_a && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, wr0, rw00;
        bit found;
        for (int i = 0; i < 128; i++) sa0_a[i] = '0;
        reset   = 1'b1;
        start_a = 1'b0; men_a = 1'b0; mode_a = '0; maddr_a = '0;
        start_b = 1'b0; mode_b = '0;
        repeat (3) @(negedge clk);
        check("rst_ctl",  {cs_n_a, oe_n_a, rw_a}, 3'b111);
        check("rst_addr", addr_a, 0);
        check("rst_wdat", wdata_a, 0);
        check("rst_stat", {busy_a, done_a, pass_a}, 0);
        check("rst_err",  err_a, 0);
        check("rst_ff",   ff_a, 0);
        check("rst_man",  mdata_a, 0);
        reset = 1'b0;

        // Ideal memory, DESC pattern
        wr0 = wr_a; rw00 = rw0_a;
        run_a(2'd0, lat);
        check("t1_lat",    lat, 640);
        check("t1_wcyc",   rw0_a - rw00, 384);
        check("t1_wstrb",  wr_a - wr0, 128);
        check("t1_pass",   {busy_a, done_a, pass_a}, 3'b011);
        check("t1_err",    err_a, 0);
        check("t1_ff",     ff_a, 0);
        check("t1_mem5",   mem_a[5], 122);
        check("t1_mem0",   mem_a[0], 127);
        check("t1_mem127", mem_a[127], 0);
        check("t1_idle",   {cs_n_a, oe_n_a, rw_a}, 3'b111);

        // Manual read of address 5
        wr0 = wr_a;
        maddr_a = 7'd5; men_a = 1'b1;
        @(negedge clk);
        check("t4_bus",  {cs_n_a, oe_n_a, rw_a}, 3'b001);
        check("t4_addr", addr_a, 5);
        repeat (2) @(negedge clk);
        check("t4_data", mdata_a, 122);
        check("t4_rw",   rw_a, 1);
        check("t4_stat", {busy_a, done_a, pass_a}, 3'b011);
        men_a = 1'b0; maddr_a = 7'd6;
        repeat (3) @(negedge clk);
        check("t4_hold", mdata_a, 122);
        check("t4_idle", cs_n_a, 1);
        check("t4_nowr", wr_a - wr0, 0);

        // Stuck-at-0 bit0 at 17, ADDR pattern; manual_en high alongside start
        sa0_a[17] = 7'h01;
        men_a = 1'b1;
        run_a(2'd1, lat);
        men_a = 1'b0;
        check("t2_lat",  lat, 640);
        check("t2_pass", {done_a, pass_a}, 2'b10);
        check("t2_err",  err_a, 1);
        check("t2_ff",   ff_a, 17);

        // Two faults under CHECKER, then only the later one
        sa0_a[17] = '0; sa0_a[3] = 7'h02; sa0_a[90] = 7'h01;
        run_a(2'd2, lat);
        check("t3a_err",  err_a, 2);
        check("t3a_ff",   ff_a, 3);
        check("t3a_pass", pass_a, 0);
        check("t3_mem3",  mem_a[3], 7'h2A);
        check("t3_mem4",  mem_a[4], 7'h55);
        sa0_a[3] = '0;
        run_a(2'd2, lat);
        check("t3b_err",  err_a, 1);
        check("t3b_ff",   ff_a, 90);

        // INV_ADDR, ideal memory
        sa0_a[90] = '0;
        run_a(2'd3, lat);
        check("inv_pass",  {done_a, pass_a, err_a}, {2'b11, 8'd0});
        check("inv_mem10", mem_a[10], 117);

        // Reset during the write strobe of address 40
        @(negedge clk);
        mode_a = 2'd1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (addr_a == 7'd40 && !cs_n_a && !rw_a) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t5_reach40", found, 1);
        reset = 1'b1;
        #1;
        check("t5_ctl",  {cs_n_a, oe_n_a, rw_a}, 3'b111);
        check("t5_addr", {addr_a, wdata_a}, 0);
        check("t5_stat", {busy_a, done_a, pass_a, err_a, ff_a, mdata_a}, 0);
        @(negedge clk);
        reset = 1'b0;
        run_a(2'd0, lat);
        check("t5_lat",  lat, 640);
        check("t5_pass", pass_a, 1);

        // DEPTH 100, RD_LAT 3, start re-pulsed while busy
        @(negedge clk);
        mode_b = 2'd0; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("t6_busy", busy_b, 1);
        lat = 0;
        while (!done_b && lat < 3000) begin
            start_b = (lat == 10 || lat == 500);
            @(negedge clk);
            lat++;
        end
        start_b = 1'b0;
        check("t6_lat",   lat, 700);
        check("t6_pass",  {done_b, pass_b}, 2'b11);
        check("t6_err",   err_b, 0);
        check("t6_max",   max_b, 99);
        check("t6_mem99", mem_b[99], 28);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
